// File: rtl/mem_resp_pkg.sv
// Shared types, default sizes and the address-window decode for mem_responder.
package mem_resp_pkg;

  localparam int DEF_RAM_WIDTH = 512;
  localparam int DEF_DEPTH     = 1024;
  localparam int READ_LATENCY  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  // The subtraction wraps, so addresses below the base land far out of range.
  function automatic logic addr_in_range(input logic [63:0] addr,
                                         input logic [63:0] base,
                                         input logic [63:0] depth);
    logic [63:0] offset;
    offset = addr - base;
    return offset < depth;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Initiator-side bus bundle for one mem_responder port (addr/read/write/byte_enable/wait_req/lock).
interface mem_responder_if
  import mem_resp_pkg::*;
#(
  parameter int RAM_WIDTH = DEF_RAM_WIDTH
) ();

  localparam int BE_WIDTH = RAM_WIDTH / 8;

  logic [63:0]          addr;
  logic                 read;
  logic                 write;
  logic [BE_WIDTH-1:0]  byte_enable;
  logic [RAM_WIDTH-1:0] write_data;
  logic                 lock;
  logic                 wait_req;
  logic [RAM_WIDTH-1:0] read_data;

  modport master (
    output addr, read, write, byte_enable, write_data, lock,
    input  wait_req, read_data
  );

  modport slave (
    input  addr, read, write, byte_enable, write_data, lock,
    output wait_req, read_data
  );

endinterface

// File: rtl/mem_resp_ram.sv
// Single-port byte-enabled synchronous RAM with a registered read (first stage of the read path).
module mem_resp_ram
  import mem_resp_pkg::*;
#(
  parameter int RAM_WIDTH = DEF_RAM_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  localparam int BE_WIDTH = RAM_WIDTH / 8,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rd_en,
  input  logic                 wr_en,
  input  logic [AW-1:0]        addr,
  input  logic [BE_WIDTH-1:0]  byte_en,
  input  logic [RAM_WIDTH-1:0] wdata,
  output logic [RAM_WIDTH-1:0] rdata
);

  // One independent byte lane per enable bit keeps the write mask trivially mappable.
  generate
    for (genvar gi = 0; gi < BE_WIDTH; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] rd_q_reg;

      always_ff @(posedge clk) begin
        if (wr_en && byte_en[gi]) begin
          lane_mem[addr] <= wdata[gi*8 +: 8];
        end
        if (rd_en) begin
          rd_q_reg <= lane_mem[addr];
        end
      end

      assign rdata[gi*8 +: 8] = rd_q_reg;
    end
  endgenerate

endmodule

// File: rtl/mem_responder.sv
// Two-port arbitrated bus slave in front of the feature-map RAM, 2-cycle read latency.
// Optional MEM_RESPONDER_OOR_ERR_EN adds a sticky out-of-range flag and first-offender address.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int          RAM_WIDTH = DEF_RAM_WIDTH,
  parameter int          DEPTH     = DEF_DEPTH,
  localparam int         BE_WIDTH  = RAM_WIDTH / 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  mem_responder_if.slave       port0,
  mem_responder_if.slave       port1
`ifdef MEM_RESPONDER_OOR_ERR_EN
  ,
  output logic                 OorErr_o,
  output logic [63:0]          OorAddr_o
`endif
);

  localparam int AW = $clog2(DEPTH);

  state_t state_reg;
  state_t state_next;
  logic   rr_last_reg;
  logic   rr_last_next;
  logic   wait0_reg;
  logic   wait1_reg;
  logic   wait0_next;
  logic   wait1_next;
  logic   want0;
  logic   want1;

  assign want0 = port0.lock | port0.read | port0.write;
  assign want1 = port1.lock | port1.read | port1.write;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= IDLE;
      rr_last_reg <= 1'b1;
      wait0_reg   <= 1'b1;
      wait1_reg   <= 1'b1;
    end else begin
      state_reg   <= state_next;
      rr_last_reg <= rr_last_next;
      wait0_reg   <= wait0_next;
      wait1_reg   <= wait1_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (want0 && want1) begin
          state_next = rr_last_reg ? GRANT0 : GRANT1;
        end else if (want0) begin
          state_next = GRANT0;
        end else if (want1) begin
          state_next = GRANT1;
        end
      end
      GRANT0: begin
        if (!want0) begin
          state_next = IDLE;
        end
      end
      GRANT1: begin
        if (!want1) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // wait_req is registered from the next state so it drops together with the grant.
  always_comb begin
    rr_last_next = rr_last_reg;
    if (state_reg == IDLE && state_next == GRANT0) begin
      rr_last_next = 1'b0;
    end else if (state_reg == IDLE && state_next == GRANT1) begin
      rr_last_next = 1'b1;
    end
    wait0_next = (state_next != GRANT0);
    wait1_next = (state_next != GRANT1);
  end

  logic                 acc0;
  logic                 acc1;
  logic                 acc_any;
  logic                 acc_read;
  logic                 acc_write;
  logic                 acc_in_range;
  logic [63:0]          acc_addr;
  logic [BE_WIDTH-1:0]  acc_be;
  logic [RAM_WIDTH-1:0] acc_wdata;
  logic [AW-1:0]        ram_addr;
  logic                 ram_we;
  logic                 ram_re;
  logic                 rd_issue;
  logic [RAM_WIDTH-1:0] ram_rdata;

  assign acc0    = (port0.read | port0.write) & ~wait0_reg;
  assign acc1    = (port1.read | port1.write) & ~wait1_reg;
  assign acc_any = acc0 | acc1;

  // Only one port can hold the grant, so acc1 alone selects the winning request.
  assign acc_addr  = acc1 ? port1.addr        : port0.addr;
  assign acc_read  = acc1 ? port1.read        : port0.read;
  assign acc_write = acc1 ? port1.write       : port0.write;
  assign acc_be    = acc1 ? port1.byte_enable : port0.byte_enable;
  assign acc_wdata = acc1 ? port1.write_data  : port0.write_data;

  assign acc_in_range = addr_in_range(acc_addr, BASE_ADDR, 64'(DEPTH));
  assign ram_addr     = AW'(acc_addr - BASE_ADDR);

  // A simultaneous read+write performs only the write and leaves read data alone.
  assign rd_issue = acc_any & acc_read & ~acc_write;
  assign ram_re   = rd_issue & acc_in_range;
  assign ram_we   = acc_any & acc_write & acc_in_range;

  mem_resp_ram #(
    .RAM_WIDTH (RAM_WIDTH),
    .DEPTH     (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rd_en   (ram_re),
    .wr_en   (ram_we),
    .addr    (ram_addr),
    .byte_en (acc_be),
    .wdata   (acc_wdata),
    .rdata   (ram_rdata)
  );

  logic                 rd_v1_reg;
  logic                 rd_port1_reg;
  logic                 rd_inr_reg;
  logic [RAM_WIDTH-1:0] rdata0_reg;
  logic [RAM_WIDTH-1:0] rdata1_reg;

  // Per-port return registers form the second read stage and hold data between reads.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_v1_reg    <= 1'b0;
      rd_port1_reg <= 1'b0;
      rd_inr_reg   <= 1'b0;
      rdata0_reg   <= '0;
      rdata1_reg   <= '0;
    end else begin
      rd_v1_reg    <= rd_issue;
      rd_port1_reg <= acc1;
      rd_inr_reg   <= acc_in_range;
      if (rd_v1_reg) begin
        if (rd_port1_reg) begin
          rdata1_reg <= rd_inr_reg ? ram_rdata : '0;
        end else begin
          rdata0_reg <= rd_inr_reg ? ram_rdata : '0;
        end
      end
    end
  end

  assign port0.wait_req  = wait0_reg;
  assign port1.wait_req  = wait1_reg;
  assign port0.read_data = rdata0_reg;
  assign port1.read_data = rdata1_reg;

`ifdef MEM_RESPONDER_OOR_ERR_EN
  logic        oor_err_reg;
  logic [63:0] oor_addr_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      oor_err_reg  <= 1'b0;
      oor_addr_reg <= '0;
    end else if (acc_any && !acc_in_range) begin
      oor_err_reg <= 1'b1;
      if (!oor_err_reg) begin
        oor_addr_reg <= acc_addr;
      end
    end
  end

  assign OorErr_o  = oor_err_reg;
  assign OorAddr_o = oor_addr_reg;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: arbitration, byte writes, 2-cycle reads, range decode, reset.
`timescale 1ns/1ps
module tb_mem_responder;
  import mem_resp_pkg::*;

  localparam logic [63:0] BASE = 64'h0000_0000_0000_0100;
  localparam int          W    = 512;
  localparam int          D    = 1024;
  localparam int          BEW  = W / 8;

  typedef struct {
    int           port;
    int           due;
    logic [W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mem_responder_if #(.RAM_WIDTH(W)) if0 ();
  mem_responder_if #(.RAM_WIDTH(W)) if1 ();

`ifdef MEM_RESPONDER_OOR_ERR_EN
  logic        oor_err;
  logic [63:0] oor_addr;
`endif

  mem_responder #(
    .BASE_ADDR (BASE),
    .RAM_WIDTH (W),
    .DEPTH     (D)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .port0 (if0),
    .port1 (if1)
`ifdef MEM_RESPONDER_OOR_ERR_EN
    ,
    .OorErr_o  (oor_err),
    .OorAddr_o (oor_addr)
`endif
  );

  int           checks = 0;
  int           errors = 0;
  int           cyc    = 0;
  exp_t         exp_q[$];
  logic [W-1:0] model [int];

  initial begin
    #2000000;
    $display("FAIL watchdog cycle %0d required finish", cyc);
    $fatal(1, "timeout");
  end

  task automatic step();
    exp_t         e;
    logic [W-1:0] obs;
    @(posedge clk);
    cyc++;
    #1;
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e   = exp_q.pop_front();
      obs = (e.port == 0) ? if0.read_data : if1.read_data;
      checks++;
      if (e.due != cyc || obs !== e.data) begin
        errors++;
        $display("FAIL sb_read port%0d cyc %0d due %0d got %h want %h", e.port, cyc, e.due, obs, e.data);
      end
    end
  endtask

  task automatic drive(input int p, input logic rd, input logic wr, input logic [63:0] a,
                       input logic [BEW-1:0] be, input logic [W-1:0] d, input logic lk);
    if (p == 0) begin
      if0.read = rd; if0.write = wr; if0.addr = a;
      if0.byte_enable = be; if0.write_data = d; if0.lock = lk;
    end else begin
      if1.read = rd; if1.write = wr; if1.addr = a;
      if1.byte_enable = be; if1.write_data = d; if1.lock = lk;
    end
  endtask

  task automatic idle(input int p);
    drive(p, 1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  // Drives a locked access, waits for the grant, records the expectation, then drops strobes.
  task automatic access(input int p, input logic rd, input logic wr, input logic [63:0] a,
                        input logic [BEW-1:0] be, input logic [W-1:0] d);
    int           n;
    logic         wq;
    logic [63:0]  off;
    logic [W-1:0] cur;
    exp_t         e;
    n = 0;
    drive(p, rd, wr, a, be, d, 1'b1);
    wq = (p == 0) ? if0.wait_req : if1.wait_req;
    while (wq !== 1'b0 && n < 20) begin
      step();
      n++;
      wq = (p == 0) ? if0.wait_req : if1.wait_req;
    end
    checks++;
    if (wq !== 1'b0) begin
      errors++;
      $display("FAIL grant port%0d wait_req %b required 0", p, wq);
      drive(p, 1'b0, 1'b0, a, be, d, 1'b1);
      return;
    end
    off = a - BASE;
    if (wr) begin
      if (off < 64'(D)) begin
        cur = model.exists(int'(off)) ? model[int'(off)] : '0;
        for (int b = 0; b < BEW; b++) begin
          if (be[b]) cur[b*8 +: 8] = d[b*8 +: 8];
        end
        model[int'(off)] = cur;
      end
    end else if (rd) begin
      e.port = p;
      e.due  = cyc + READ_LATENCY;
      e.data = (off < 64'(D)) ? model[int'(off)] : '0;
      exp_q.push_back(e);
    end
    $display("acc cyc %0d port%0d rd %0b wr %0b addr %h", cyc, p, rd, wr, a);
    step();
    drive(p, 1'b0, 1'b0, a, be, d, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    idle(0); idle(1);
    rstn = 1'b0;
    exp_q.delete();
    step(); step();
    checks += 4;
    if (if0.wait_req !== 1'b1) begin errors++; $display("FAIL rst_wait0 got %b want 1", if0.wait_req); end
    if (if1.wait_req !== 1'b1) begin errors++; $display("FAIL rst_wait1 got %b want 1", if1.wait_req); end
    if (if0.read_data !== '0) begin errors++; $display("FAIL rst_rd0 got %h want 0", if0.read_data); end
    if (if1.read_data !== '0) begin errors++; $display("FAIL rst_rd1 got %h want 0", if1.read_data); end
`ifdef MEM_RESPONDER_OOR_ERR_EN
    checks += 2;
    if (oor_err !== 1'b0) begin errors++; $display("FAIL rst_oor_err got %b want 0", oor_err); end
    if (oor_addr !== 64'h0) begin errors++; $display("FAIL rst_oor_addr got %h want 0", oor_addr); end
`endif
    rstn = 1'b1;
    step();
  endtask

  task automatic test_single_port();
    access(0, 1'b0, 1'b1, BASE + 64'd5, {BEW{1'b1}}, {BEW{8'hA5}});
    checks++;
    if (if1.wait_req !== 1'b1) begin errors++; $display("FAIL sp_wait1 got %b want 1", if1.wait_req); end
    access(0, 1'b1, 1'b0, BASE + 64'd5, '0, '0);
    checks++;
    if (if0.read_data !== '0) begin errors++; $display("FAIL sp_early got %h want 0", if0.read_data); end
    drain();
    step(); step();
    checks += 2;
    if (if0.read_data !== {BEW{8'hA5}}) begin errors++; $display("FAIL sp_hold got %h want a5", if0.read_data); end
    if (if1.wait_req !== 1'b1) begin errors++; $display("FAIL sp_wait1_end got %b want 1", if1.wait_req); end
    idle(0);
    step();
  endtask

  task automatic test_partial_write();
    logic [W-1:0] want;
    want = '0;
    want[7:0] = 8'hFF;
    access(0, 1'b0, 1'b1, BASE + 64'd7, {BEW{1'b1}}, '0);
    access(0, 1'b0, 1'b1, BASE + 64'd7, {{(BEW-1){1'b0}}, 1'b1}, {W{1'b1}});
    access(0, 1'b1, 1'b0, BASE + 64'd7, '0, '0);
    drain();
    checks++;
    if (if0.read_data !== want) begin errors++; $display("FAIL partial got %h want %h", if0.read_data, want); end
    idle(0);
    step();
  endtask

  task automatic test_contention();
    rstn = 1'b0;
    exp_q.delete();
    step();
    rstn = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    drive(1, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    step();
    checks += 2;
    if (if0.wait_req !== 1'b0) begin errors++; $display("FAIL tie1_wait0 got %b want 0", if0.wait_req); end
    if (if1.wait_req !== 1'b1) begin errors++; $display("FAIL tie1_wait1 got %b want 1", if1.wait_req); end
    idle(0);
    step();
    checks += 2;
    if (if0.wait_req !== 1'b1) begin errors++; $display("FAIL drop_wait0 got %b want 1", if0.wait_req); end
    if (if1.wait_req !== 1'b1) begin errors++; $display("FAIL drop_wait1 got %b want 1", if1.wait_req); end
    step();
    checks += 2;
    if (if0.wait_req !== 1'b1) begin errors++; $display("FAIL g1_wait0 got %b want 1", if0.wait_req); end
    if (if1.wait_req !== 1'b0) begin errors++; $display("FAIL g1_wait1 got %b want 0", if1.wait_req); end
    access(1, 1'b0, 1'b1, BASE + 64'd9, {BEW{1'b1}}, {BEW{8'h3C}});
    access(1, 1'b1, 1'b0, BASE + 64'd9, '0, '0);
    drain();
    idle(1);
    step();
    drive(0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    drive(1, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    step();
    checks += 2;
    if (if0.wait_req !== 1'b0) begin errors++; $display("FAIL tie2_wait0 got %b want 0", if0.wait_req); end
    if (if1.wait_req !== 1'b1) begin errors++; $display("FAIL tie2_wait1 got %b want 1", if1.wait_req); end
    idle(0); idle(1);
    step(); step();
  endtask

  task automatic test_out_of_range();
    logic [W-1:0] pat;
    pat = {16{$urandom()}};
    access(0, 1'b0, 1'b1, BASE, {BEW{1'b1}}, pat);
    access(0, 1'b1, 1'b0, BASE + 64'd7, '0, '0);
    access(0, 1'b1, 1'b0, BASE + 64'(D), '0, '0);
    drain();
    checks++;
    if (if0.read_data !== '0) begin errors++; $display("FAIL oor_read got %h want 0", if0.read_data); end
`ifdef MEM_RESPONDER_OOR_ERR_EN
    checks += 2;
    if (oor_err !== 1'b1) begin errors++; $display("FAIL oor_err got %b want 1", oor_err); end
    if (oor_addr !== BASE + 64'(D)) begin errors++; $display("FAIL oor_addr got %h want %h", oor_addr, BASE + 64'(D)); end
`endif
    access(0, 1'b0, 1'b1, BASE + 64'(D), {BEW{1'b1}}, ~pat);
    access(0, 1'b1, 1'b0, BASE, '0, '0);
    access(0, 1'b1, 1'b0, BASE - 64'd1, '0, '0);
    access(0, 1'b1, 1'b0, BASE, '0, '0);
    drain();
`ifdef MEM_RESPONDER_OOR_ERR_EN
    checks += 2;
    if (oor_err !== 1'b1) begin errors++; $display("FAIL oor_err_keep got %b want 1", oor_err); end
    if (oor_addr !== BASE + 64'(D)) begin errors++; $display("FAIL oor_addr_keep got %h want %h", oor_addr, BASE + 64'(D)); end
`endif
    idle(0);
    step();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] last0;
    logic [W-1:0] old1;
    int           n;
    for (int i = 0; i < 4; i++) begin
      access(0, 1'b0, 1'b1, BASE + 64'(i), {BEW{1'b1}}, {16{$urandom()}});
    end
    for (int i = 0; i < 4; i++) begin
      access(0, 1'b1, 1'b0, BASE + 64'(i), '0, '0);
    end
    idle(0);
    drain();
    last0 = model[3];
    old1  = model[9];
    drive(0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    n = 0;
    while (if0.wait_req !== 1'b0 && n < 20) begin step(); n++; end
    drive(1, 1'b1, 1'b0, BASE + 64'd2, '0, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks += 2;
      if (if1.wait_req !== 1'b1) begin errors++; $display("FAIL held_wait1 got %b want 1", if1.wait_req); end
      if (if1.read_data !== old1) begin errors++; $display("FAIL held_rd1 got %h want %h", if1.read_data, old1); end
    end
    idle(0);
    access(1, 1'b1, 1'b0, BASE + 64'd2, '0, '0);
    idle(1);
    drain();
    checks++;
    if (if0.read_data !== last0) begin errors++; $display("FAIL steer_rd0 got %h want %h", if0.read_data, last0); end
    access(0, 1'b1, 1'b1, BASE + 64'd1, {BEW{1'b1}}, {BEW{8'h5A}});
    step(); step(); step();
    checks++;
    if (if0.read_data !== last0) begin errors++; $display("FAIL rw_hold got %h want %h", if0.read_data, last0); end
    access(0, 1'b1, 1'b0, BASE + 64'd1, '0, '0);
    idle(0);
    drain();
    step();
  endtask

  task automatic test_reset_mid_read();
    access(0, 1'b1, 1'b0, BASE + 64'd5, '0, '0);
    rstn = 1'b0;
    exp_q.delete();
    #1;
    checks += 3;
    if (if0.read_data !== '0) begin errors++; $display("FAIL mid_rd0 got %h want 0", if0.read_data); end
    if (if0.wait_req !== 1'b1) begin errors++; $display("FAIL mid_wait0 got %b want 1", if0.wait_req); end
    if (if1.wait_req !== 1'b1) begin errors++; $display("FAIL mid_wait1 got %b want 1", if1.wait_req); end
    idle(0);
    step(); step();
    checks++;
    if (if0.read_data !== '0) begin errors++; $display("FAIL mid_discard got %h want 0", if0.read_data); end
    rstn = 1'b1;
    step();
    access(0, 1'b1, 1'b0, BASE + 64'd2, '0, '0);
    access(0, 1'b1, 1'b0, BASE + 64'd5, '0, '0);
    idle(0);
    drain();
  endtask

  initial begin
    idle(0);
    idle(1);
    test_reset();
    test_single_port();
    test_partial_write();
    test_contention();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
